// File: rtl/mat_mult_pkg.sv
// Shared types and constants for the 3x3 byte-element matrix multiplier and its controller.
package mat_mult_pkg;
    localparam int ELEM_W = 8;
    localparam int DIM    = 3;
    localparam int N_ELEM = DIM * DIM;
    localparam int MAT_W  = N_ELEM * ELEM_W;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [MAT_W-1:0]  mat_t;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Row-major element k sits at bits [71-8k -: 8], so its lsb is 64-8k.
    function automatic logic [6:0] elem_lsb(input logic [3:0] k);
        return 7'(MAT_W - ELEM_W - ELEM_W * int'(k));
    endfunction
endpackage

// File: rtl/mat_elem_reg.sv
// 72-bit operand register written one row-major byte element at a time.
module mat_elem_reg
    import mat_mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] idx,
    input  elem_t      data,
    output mat_t       q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wr_en && idx < 4'(N_ELEM)) begin
            q[elem_lsb(idx) +: ELEM_W] <= data;
        end
    end
endmodule

// File: rtl/mat_mult.sv
// Combinational 3x3 matrix multiply, 8-bit elements, each result truncated mod 256.
module mat_mult
    import mat_mult_pkg::*;
(
    input  logic [MAT_W-1:0] A,
    input  logic [MAT_W-1:0] B,
    output logic [MAT_W-1:0] Res
);
    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            elem_t a0, a1, a2, b0, b1, b2;
            assign a0 = A[MAT_W-1-ELEM_W*(i*DIM+0) -: ELEM_W];
            assign a1 = A[MAT_W-1-ELEM_W*(i*DIM+1) -: ELEM_W];
            assign a2 = A[MAT_W-1-ELEM_W*(i*DIM+2) -: ELEM_W];
            assign b0 = B[MAT_W-1-ELEM_W*(0*DIM+j) -: ELEM_W];
            assign b1 = B[MAT_W-1-ELEM_W*(1*DIM+j) -: ELEM_W];
            assign b2 = B[MAT_W-1-ELEM_W*(2*DIM+j) -: ELEM_W];
            // 8-bit assignment context drops the carries: mod-256 by construction.
            assign Res[MAT_W-1-ELEM_W*(i*DIM+j) -: ELEM_W] = a0 * b0 + a1 * b1 + a2 * b2;
        end
    end
endmodule

// File: rtl/mat_mult_seq_ctrl.sv
// Streams A then B in as bytes, lets mat_mult settle, captures the product and streams it out.
module mat_mult_seq_ctrl
    import mat_mult_pkg::*;
#(
    parameter int COMPUTE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       done
);
    localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);
    localparam logic [3:0] WAIT_END = 4'(COMPUTE_LAT - 1);

    state_t     state;
    logic [3:0] elem_cnt;
    logic [3:0] elem_nxt;
    logic [3:0] wait_cnt;
    mat_t       a_q, b_q, res, res_q;
    logic       in_hs, out_hs, wr_a, wr_b;

    assign elem_nxt = elem_cnt + 4'd1;
    assign in_hs    = in_valid && in_ready && !clear;
    assign out_hs   = out_valid && out_ready && !clear;
    assign wr_a     = in_hs && (state == LOAD_A);
    assign wr_b     = in_hs && (state == LOAD_B);

    mat_elem_reg u_a_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_a),
        .idx   (elem_cnt),
        .data  (in_data),
        .q     (a_q)
    );

    mat_elem_reg u_b_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_b),
        .idx   (elem_cnt),
        .data  (in_data),
        .q     (b_q)
    );

    mat_mult u_mult (
        .A   (a_q),
        .B   (b_q),
        .Res (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            elem_cnt  <= '0;
            wait_cnt  <= '0;
            res_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state     <= LOAD_A;
                elem_cnt  <= '0;
                wait_cnt  <= '0;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    LOAD_A: begin
                        in_ready <= 1'b1;
                        if (in_hs) begin
                            if (elem_cnt == LAST_IDX) begin
                                elem_cnt <= '0;
                                state    <= LOAD_B;
                            end else begin
                                elem_cnt <= elem_nxt;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (in_hs) begin
                            if (elem_cnt == LAST_IDX) begin
                                elem_cnt <= '0;
                                wait_cnt <= '0;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                                state    <= WAIT;
                            end else begin
                                elem_cnt <= elem_nxt;
                            end
                        end
                    end
                    WAIT: begin
                        // Operand registers are frozen here, so res is stable by the capture cycle.
                        if (wait_cnt == WAIT_END) begin
                            res_q     <= res;
                            elem_cnt  <= '0;
                            out_valid <= 1'b1;
                            out_data  <= res[elem_lsb(4'd0) +: ELEM_W];
                            out_last  <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                    DRAIN: begin
                        if (out_hs) begin
                            if (elem_cnt == LAST_IDX) begin
                                elem_cnt  <= '0;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                busy      <= 1'b0;
                                in_ready  <= 1'b1;
                                done      <= 1'b1;
                                state     <= LOAD_A;
                            end else begin
                                elem_cnt <= elem_nxt;
                                out_data <= res_q[elem_lsb(elem_nxt) +: ELEM_W];
                                out_last <= (elem_nxt == LAST_IDX);
                            end
                        end
                    end
                    default: begin
                        state     <= LOAD_A;
                        elem_cnt  <= '0;
                        wait_cnt  <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
